// File: rtl/modport_alu_pkg.sv
// Shared types and constants for the 8-bit registered ALU.
package modport_alu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] DIV_BY_ZERO_RESULT = 8'hFF;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

endpackage

// File: rtl/modport_alu_core.sv
// Combinational ALU datapath: result byte and carry/borrow flag for one opcode.
module alu_core
  import modport_alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] r,
  output logic              c
);

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] prod;

  // Ninth bit of the zero-extended difference is the borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  always_comb begin
    r = '0;
    c = 1'b0;
    case (op)
      OP_ADD:  begin r = sum[DATA_W-1:0];  c = sum[DATA_W]; end
      OP_SUB:  begin r = diff[DATA_W-1:0]; c = diff[DATA_W]; end
      OP_MUL:  begin r = prod[DATA_W-1:0]; c = |prod[2*DATA_W-1:DATA_W]; end
      OP_DIV: begin
        if (b == '0) begin
          r = DIV_BY_ZERO_RESULT;
          c = 1'b1;
        end else begin
          r = a / b;
        end
      end
      OP_SHL:  begin r = {a[DATA_W-2:0], 1'b0}; c = a[DATA_W-1]; end
      OP_SHR:  begin r = {1'b0, a[DATA_W-1:1]}; c = a[0]; end
      OP_ROL:  r = {a[DATA_W-2:0], a[DATA_W-1]};
      OP_ROR:  r = {a[0], a[DATA_W-1:1]};
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XNOR: r = ~(a ^ b);
      OP_GT:   r = {{(DATA_W-1){1'b0}}, (a > b)};
      OP_EQ:   r = {{(DATA_W-1){1'b0}}, (a == b)};
      default: begin r = '0; c = 1'b0; end
    endcase
  end

endmodule

// File: rtl/modport_alu.sv
// 8-bit ALU with one-cycle registered result and carry; async active-low clear.
module modport_alu
  import modport_alu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        selection,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  logic [DATA_W-1:0] core_r;
  logic              core_c;

  alu_core u_core (
    .a  (a),
    .b  (b),
    .op (alu_op_e'(selection)),
    .r  (core_r),
    .c  (core_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      result    <= core_r;
      carry_out <= core_c;
    end
  end

endmodule

// File: tb/tb_modport_alu.sv
// Self-checking bench for modport_alu: directed vector table, reset sequences, random stream.
module tb_modport_alu;

  logic       clock;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] selection;
  logic [7:0] result;
  logic       carry_out;

  int checks = 0;
  int errors = 0;

  modport_alu dut (
    .clock     (clock),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .selection (selection),
    .result    (result),
    .carry_out (carry_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] r;
    logic       c;
  } vec_t;

  // Reference: opcode semantics evaluated with plain integer arithmetic.
  function automatic logic [8:0] model(input int unsigned x, input int unsigned y,
                                       input int unsigned sel);
    int unsigned r;
    int unsigned c;
    r = 0;
    c = 0;
    case (sel)
      0:  begin r = (x + y) % 256; c = ((x + y) >= 256) ? 1 : 0; end
      1:  begin r = (x + 256 - y) % 256; c = (x < y) ? 1 : 0; end
      2:  begin r = (x * y) % 256; c = ((x * y) >= 256) ? 1 : 0; end
      3:  begin
            if (y == 0) begin r = 255; c = 1; end
            else r = x / y;
          end
      4:  begin r = (x * 2) % 256; c = x / 128; end
      5:  begin r = x / 2; c = x % 2; end
      6:  r = (x * 2) % 256 + x / 128;
      7:  r = x / 2 + (x % 2) * 128;
      8:  r = x & y;
      9:  r = x | y;
      10: r = x ^ y;
      11: r = 255 - (x | y);
      12: r = 255 - (x & y);
      13: r = 255 - (x ^ y);
      14: r = (x > y) ? 1 : 0;
      default: r = (x == y) ? 1 : 0;
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic check(input string name, input logic [7:0] er, input logic ec);
    checks++;
    if (result !== er || carry_out !== ec) begin
      errors++;
      $display("FAIL %s: result=%h carry_out=%b, expected result=%h carry_out=%b",
               name, result, carry_out, er, ec);
    end
  endtask

  vec_t        vecs[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  e;
  logic [8:0]  prev;
  logic        skip_wait;

  initial begin
    vecs.push_back('{8'hF0, 8'h20, 4'd0,  8'h10, 1'b1});
    vecs.push_back('{8'h03, 8'h04, 4'd0,  8'h07, 1'b0});
    vecs.push_back('{8'h05, 8'h07, 4'd1,  8'hFE, 1'b1});
    vecs.push_back('{8'h10, 8'h10, 4'd2,  8'h00, 1'b1});
    vecs.push_back('{8'd100, 8'd7, 4'd3,  8'd14, 1'b0});
    vecs.push_back('{8'd9,  8'd0,  4'd3,  8'hFF, 1'b1});
    vecs.push_back('{8'h81, 8'h0F, 4'd4,  8'h02, 1'b1});
    vecs.push_back('{8'h81, 8'h0F, 4'd5,  8'h40, 1'b1});
    vecs.push_back('{8'h81, 8'h0F, 4'd6,  8'h03, 1'b0});
    vecs.push_back('{8'h81, 8'h0F, 4'd7,  8'hC0, 1'b0});
    vecs.push_back('{8'h81, 8'h0F, 4'd8,  8'h01, 1'b0});
    vecs.push_back('{8'h81, 8'h0F, 4'd9,  8'h8F, 1'b0});
    vecs.push_back('{8'h81, 8'h0F, 4'd10, 8'h8E, 1'b0});
    vecs.push_back('{8'h81, 8'h0F, 4'd11, 8'h70, 1'b0});
    vecs.push_back('{8'h81, 8'h0F, 4'd12, 8'hFE, 1'b0});
    vecs.push_back('{8'h81, 8'h0F, 4'd13, 8'h71, 1'b0});
    vecs.push_back('{8'h81, 8'h0F, 4'd14, 8'h01, 1'b0});
    vecs.push_back('{8'h81, 8'h0F, 4'd15, 8'h00, 1'b0});
    vecs.push_back('{8'h0F, 8'h81, 4'd14, 8'h00, 1'b0});
    vecs.push_back('{8'h5A, 8'h5A, 4'd15, 8'h01, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 4'd2,  8'h01, 1'b1});
    vecs.push_back('{8'h07, 8'h07, 4'd1,  8'h00, 1'b0});

    // Reset held with live operands: outputs must stay clear.
    reset     = 1'b0;
    a         = 8'h55;
    b         = 8'hAA;
    selection = 4'd0;
    repeat (2) @(posedge clock);
    #8 check("reset_hold", 8'h00, 1'b0);

    @(posedge clock);
    #2 reset = 1'b1;

    foreach (vecs[i]) begin
      a         = vecs[i].a;
      b         = vecs[i].b;
      selection = vecs[i].sel;
      @(posedge clock);
      #8 check($sformatf("vec%0d_op%0d", i, vecs[i].sel), vecs[i].r, vecs[i].c);
      @(posedge clock);
      #2;
    end

    // Asynchronous clear: output is nonzero, then reset drops between edges.
    a = 8'hF0; b = 8'h20; selection = 4'd0;
    @(posedge clock);
    #3 check("pre_async_clear", 8'h10, 1'b1);
    reset = 1'b0;
    #1 check("async_clear", 8'h00, 1'b0);
    @(posedge clock);
    #2 reset = 1'b1;

    // Ten back-to-back operations; reset pulsed during operation 6.
    prev      = '0;
    skip_wait = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      a         = 8'($urandom);
      b         = 8'($urandom);
      selection = 4'($urandom);
      e         = model(a, b, selection);
      if (k == 6) begin
        #1 if (k > 1) check($sformatf("stream_op%0d", k - 1), prev[7:0], prev[8]);
        #1 reset = 1'b0;
        #1 check("stream_rst_immediate", 8'h00, 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
        prev      = '0;
        skip_wait = 1'b1;
      end else begin
        #6 if (k > 1) check(k == 7 ? "stream_op6_discarded" : $sformatf("stream_op%0d", k - 1),
                            prev[7:0], prev[8]);
        prev = e;
      end
      if (!skip_wait) begin
        @(posedge clock);
        #2;
      end
      skip_wait = 1'b0;
    end
    #6 check("stream_op10", prev[7:0], prev[8]);

    // Longer random sweep against the reference, pipelined one op per clock.
    @(posedge clock);
    #2;
    for (int k = 0; k < 60; k++) begin
      a         = 8'($urandom);
      b         = (k % 8 == 0) ? 8'h00 : 8'($urandom);
      selection = 4'($urandom_range(15, 0));
      exp_q.push_back(model(a, b, selection));
      @(posedge clock);
      #8;
      e = exp_q.pop_front();
      check($sformatf("rand%0d", k), e[7:0], e[8]);
      @(posedge clock);
      #2;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
